// File: rtl/adder.sv
// Ripple-carry adder: {cout,sum} = a + b + cin, built from a chain of full-adder cells.
// REG_OUT selects a registered result (1-cycle latency, synchronous reset) or a pure combinational path.
module adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] sum_comb;
  logic             cout_comb;
  logic             carry;

  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // before the loop, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sum_comb = '0;
    carry    = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_comb[i] = a[i] ^ b[i] ^ carry;
      carry       = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout_comb = carry;
  end

  if (REG_OUT) begin : g_reg
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum  <= '0;
        cout <= 1'b0;
      end else begin
        sum  <= sum_comb;
        cout <= cout_comb;
      end
    end
  end else begin : g_comb
    assign sum  = sum_comb;
    assign cout = cout_comb;

    // Clock and reset have no function in the bypass build.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: registered 1-bit and 8-bit builds via a scoreboard queue,
// plus a combinational 1-bit build driven without any clock.
module tb_adder;

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       sum1, cout1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8;
  logic       cout8;
  logic       clk_c, rst_c;
  logic       ac, bc, cc;
  logic       sumc, coutc;

  int checks = 0;
  int errors = 0;

  logic [1:0] q1[$];
  logic [8:0] q8[$];

  // Full-adder truth table indexed by {a,b,cin}, value {cout,sum}.
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  adder #(.WIDTH(1), .REG_OUT(1'b1)) u_add1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1)
  );

  adder #(.WIDTH(8), .REG_OUT(1'b1)) u_add8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
  );

  adder #(.WIDTH(1), .REG_OUT(1'b0)) u_addc (
    .clk(clk_c), .rst(rst_c), .a(ac), .b(bc), .cin(cc), .sum(sumc), .cout(coutc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the oldest scoreboard entries for the registered builds.
  task automatic tick_check1(input string tag);
    logic [1:0] e;
    @(posedge clk);
    #1;
    e = q1.pop_front();
    check(tag, {14'd0, cout1, sum1}, {14'd0, e});
  endtask

  task automatic tick_check8(input string tag);
    logic [8:0] e;
    @(posedge clk);
    #1;
    e = q8.pop_front();
    check(tag, {7'd0, cout8, sum8}, {7'd0, e});
  endtask

  initial begin
    logic [2:0] v;
    clk_c = 1'b0;
    rst_c = 1'b0;
    ac = 1'b0; bc = 1'b0; cc = 1'b0;

    // Reset for two cycles with active inputs; outputs must be forced to zero.
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q1.push_back(2'b00);
      @(posedge clk);
      #1;
      check("reset_w1", {14'd0, cout1, sum1}, {14'd0, q1.pop_front()});
      check("reset_w8", {7'd0, cout8, sum8}, 16'd0);
    end
    rst = 1'b0;

    // Exhaustive truth table, one vector per cycle.
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      {a1, b1, cin1} = v;
      q1.push_back(tt[k]);
      tick_check1($sformatf("truth_%0d", k));
    end

    // Reset asserted on the same cycle as 1+1+1 wins over the load.
    {a1, b1, cin1} = 3'b111;
    rst = 1'b1;
    q1.push_back(2'b00);
    tick_check1("reset_priority");
    rst = 1'b0;
    q1.push_back(2'b11);
    tick_check1("load_after_reset");

    // Reset raised between edges must not touch the outputs until the next edge.
    #4;
    rst = 1'b1;
    #1;
    check("sync_rst_hold_a", {14'd0, cout1, sum1}, 16'h0003);
    #2;
    check("sync_rst_hold_b", {14'd0, cout1, sum1}, 16'h0003);
    q1.push_back(2'b00);
    tick_check1("sync_rst_edge");
    rst = 1'b0;

    // 8-bit directed carry cases on consecutive cycles.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; q8.push_back(9'h100);
    tick_check8("w8_ff_00_1");
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; q8.push_back(9'h080);
    tick_check8("w8_7f_01_0");
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; q8.push_back(9'h1FF);
    tick_check8("w8_ff_ff_1");
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; q8.push_back(9'h000);
    tick_check8("w8_zero");

    // 1000 random vectors back to back against the reference sum.
    for (int n = 0; n < 1000; n++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
      tick_check8("w8_random");
    end

    // Combinational build: binary count toggles cin every 10 ns, b every 20 ns, a every 40 ns.
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      {ac, bc, cc} = v;
      rst_c = 1'($urandom_range(0, 1));
      #2;
      check($sformatf("comb_%0d", k), {14'd0, coutc, sumc}, {14'd0, tt[k]});
      #8;
    end

    check("scoreboard_drained", 16'(q1.size() + q8.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
